// File: rtl/snn_window_classifier.sv
// Two-layer LIF spiking classifier. Weights load at runtime and thresholds adapt.
// One inference runs over a window of T_STEPS accepted timesteps and ends with an argmax readout.
module snn_window_classifier #(
  parameter int N_IN        = 8,
  parameter int N_HID       = 3,
  parameter int N_OUT       = 10,
  parameter int W_W         = 4,
  parameter int V_W         = 8,
  parameter int T_STEPS     = 64,
  parameter int LEAK_SHIFT  = 1,
  parameter int THRESH_INIT = 32,
  parameter int THRESH_INC  = 2,
  parameter int THRESH_DEC  = 1,
  parameter int THRESH_MIN  = 16,
  localparam int NWH        = N_HID * N_IN,
  localparam int NWO        = N_OUT * N_HID,
  localparam int ADDR_W     = $clog2((NWH > NWO) ? NWH : NWO),
  localparam int CLS_W      = $clog2(N_OUT)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               in_valid_i,
  input  logic [N_IN-1:0]    spike_i,
  input  logic               wt_we_i,
  input  logic               wt_sel_i,
  input  logic [ADDR_W-1:0]  wt_addr_i,
  input  logic [W_W-1:0]     wt_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CLS_W-1:0]   class_o,
  output logic               no_spike_o,
  output logic [N_HID-1:0]   hid_spike_o,
  output logic [N_OUT-1:0]   out_spike_o
);

  localparam int HC_W   = W_W + $clog2(N_IN + 1);
  localparam int OC_W   = W_W + $clog2(N_HID + 1);
  localparam int CUR_W  = (HC_W > OC_W) ? HC_W : OC_W;
  localparam int SUM_W  = ((V_W > CUR_W) ? V_W : CUR_W) + 1;
  localparam int CNT_W  = $clog2(T_STEPS + 1);
  localparam int V_MAX  = (2 ** V_W) - 1;

  localparam logic [V_W-1:0]   V_MAX_V    = '1;
  localparam logic [V_W-1:0]   THR_INIT_V = V_W'(THRESH_INIT);
  localparam logic [V_W-1:0]   THR_MIN_V  = V_W'(THRESH_MIN);
  localparam logic [V_W-1:0]   THR_DEC_V  = V_W'(THRESH_DEC);
  localparam logic [CNT_W-1:0] LAST_STEP  = CNT_W'(T_STEPS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DECIDE
  } state_e;

  typedef struct packed {
    logic [V_W-1:0] v;
    logic [V_W-1:0] thr;
    logic           fire;
  } lif_t;

  state_e state_q, state_d;

  logic [W_W-1:0]   wh_q [NWH];
  logic [W_W-1:0]   wo_q [NWO];
  logic [V_W-1:0]   hv_q [N_HID];
  logic [V_W-1:0]   hthr_q [N_HID];
  logic [V_W-1:0]   ov_q [N_OUT];
  logic [V_W-1:0]   othr_q [N_OUT];
  logic [CNT_W-1:0] cnt_q [N_OUT];
  logic [CNT_W-1:0] step_q;
  logic             hid_valid_q;
  logic [N_HID-1:0] hid_spike_q;
  logic [N_OUT-1:0] out_spike_q;
  logic [CLS_W-1:0] class_q;
  logic             no_spike_q;
  logic             done_q;

  logic [HC_W-1:0]  hid_cur [N_HID];
  logic [OC_W-1:0]  out_cur [N_OUT];
  lif_t             hid_lif [N_HID];
  lif_t             out_lif [N_OUT];
  logic             start_run;
  logic             hid_en;
  logic             out_en;
  logic             decide;
  logic [CLS_W-1:0] best_idx;
  logic [CNT_W-1:0] best_cnt;

  function automatic logic [V_W-1:0] thr_up(input logic [V_W-1:0] thr);
    logic [V_W:0] t;
    t = {1'b0, thr} + (V_W+1)'(THRESH_INC);
    return (t > (V_W+1)'(V_MAX)) ? V_MAX_V : t[V_W-1:0];
  endfunction

  function automatic logic [V_W-1:0] thr_down(input logic [V_W-1:0] thr);
    return ({1'b0, thr} >= (V_W+1)'(THRESH_MIN + THRESH_DEC)) ? (thr - THR_DEC_V) : THR_MIN_V;
  endfunction

  // Leak, integrate with saturation, then fire-and-reset or decay the threshold.
  function automatic lif_t lif_step(input logic [V_W-1:0] v, input logic [V_W-1:0] thr,
                                    input logic [SUM_W-1:0] cur);
    logic [SUM_W-1:0] sum;
    logic [V_W-1:0]   v_new;
    lif_t             r;
    sum   = SUM_W'(v) - SUM_W'(v >> LEAK_SHIFT) + cur;
    v_new = (sum > SUM_W'(V_MAX)) ? V_MAX_V : sum[V_W-1:0];
    if (v_new >= thr) begin
      r.fire = 1'b1;
      r.v    = '0;
      r.thr  = thr_up(thr);
    end else begin
      r.fire = 1'b0;
      r.v    = v_new;
      r.thr  = thr_down(thr);
    end
    return r;
  endfunction

  // NOTE: every variable driven here gets a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    hid_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_RUN;
          start_run = 1'b1;
        end
      end
      S_RUN: begin
        hid_en = in_valid_i;
        if (in_valid_i && (step_q == LAST_STEP)) state_d = S_DRAIN;
      end
      S_DRAIN:  state_d = S_DECIDE;
      S_DECIDE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign out_en = hid_valid_q && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign decide = (state_q == S_DECIDE);

  always_comb begin
    for (int j = 0; j < N_HID; j++) begin
      hid_cur[j] = '0;
      for (int i = 0; i < N_IN; i++)
        hid_cur[j] = hid_cur[j] + (spike_i[i] ? HC_W'(wh_q[j*N_IN + i]) : '0);
      hid_lif[j] = lif_step(hv_q[j], hthr_q[j], SUM_W'(hid_cur[j]));
    end
    for (int k = 0; k < N_OUT; k++) begin
      out_cur[k] = '0;
      for (int j = 0; j < N_HID; j++)
        out_cur[k] = out_cur[k] + (hid_spike_q[j] ? OC_W'(wo_q[k*N_HID + j]) : '0);
      out_lif[k] = lif_step(ov_q[k], othr_q[k], SUM_W'(out_cur[k]));
    end
  end

  // A strict greater-than scan keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_cnt = cnt_q[0];
    for (int k = 1; k < N_OUT; k++) begin
      if (cnt_q[k] > best_cnt) begin
        best_cnt = cnt_q[k];
        best_idx = CLS_W'(k);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples values from before the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      hid_valid_q <= 1'b0;
      hid_spike_q <= '0;
      out_spike_q <= '0;
      class_q     <= '0;
      no_spike_q  <= 1'b0;
      done_q      <= 1'b0;
      // NOTE: the weight arrays are ordinary flops and are cleared here on purpose, because a reset must invalidate loaded weights.
      for (int a = 0; a < NWH; a++) wh_q[a] <= '0;
      for (int a = 0; a < NWO; a++) wo_q[a] <= '0;
      for (int j = 0; j < N_HID; j++) begin
        hv_q[j]   <= '0;
        hthr_q[j] <= THR_INIT_V;
      end
      for (int k = 0; k < N_OUT; k++) begin
        ov_q[k]   <= '0;
        othr_q[k] <= THR_INIT_V;
        cnt_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= decide;

      if (wt_we_i && (state_q == S_IDLE)) begin
        if (!wt_sel_i) begin
          if ({1'b0, wt_addr_i} < (ADDR_W+1)'(NWH)) wh_q[wt_addr_i] <= wt_data_i;
        end else begin
          if ({1'b0, wt_addr_i} < (ADDR_W+1)'(NWO)) wo_q[wt_addr_i] <= wt_data_i;
        end
      end

      if (start_run) begin
        step_q      <= '0;
        hid_valid_q <= 1'b0;
        for (int j = 0; j < N_HID; j++) begin
          hv_q[j]   <= '0;
          hthr_q[j] <= THR_INIT_V;
        end
        for (int k = 0; k < N_OUT; k++) begin
          ov_q[k]   <= '0;
          othr_q[k] <= THR_INIT_V;
          cnt_q[k]  <= '0;
        end
      end else begin
        hid_valid_q <= hid_en;
        if (hid_en) begin
          step_q <= step_q + 1'b1;
          for (int j = 0; j < N_HID; j++) begin
            hv_q[j]        <= hid_lif[j].v;
            hthr_q[j]      <= hid_lif[j].thr;
            hid_spike_q[j] <= hid_lif[j].fire;
          end
        end
        // The output layer trails the hidden layer by one cycle, so it also runs in DRAIN.
        if (out_en) begin
          for (int k = 0; k < N_OUT; k++) begin
            ov_q[k]        <= out_lif[k].v;
            othr_q[k]      <= out_lif[k].thr;
            out_spike_q[k] <= out_lif[k].fire;
            if (out_lif[k].fire && (cnt_q[k] != CNT_MAX)) cnt_q[k] <= cnt_q[k] + 1'b1;
          end
        end
      end

      if (decide) begin
        class_q    <= best_idx;
        no_spike_q <= (best_cnt == '0);
      end
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign class_o     = class_q;
  assign no_spike_o  = no_spike_q;
  assign hid_spike_o = hid_spike_q;
  assign out_spike_o = out_spike_q;

endmodule

// File: tb/tb_snn_window_classifier.sv
// Bench for snn_window_classifier. A step-level reference network supplies the expected
// spikes, class and latency for directed cases and for randomized weights, inputs and stalls.
module tb_snn_window_classifier;

  localparam int N_IN = 8, N_HID = 3, N_OUT = 10, W_W = 4, V_W = 8, T_STEPS = 64;
  localparam int LEAK_SHIFT = 1, THRESH_INIT = 32, THRESH_INC = 2, THRESH_DEC = 1, THRESH_MIN = 16;
  localparam int ADDR_W = 5, CLS_W = 4, CNT_SAT = 127, V_MAX = 255;

  logic              clk_i = 1'b0;
  logic              rst_i, start_i, in_valid_i, wt_we_i, wt_sel_i;
  logic [N_IN-1:0]   spike_i;
  logic [ADDR_W-1:0] wt_addr_i;
  logic [W_W-1:0]    wt_data_i;
  logic              busy_o, done_o, no_spike_o;
  logic [CLS_W-1:0]  class_o;
  logic [N_HID-1:0]  hid_spike_o;
  logic [N_OUT-1:0]  out_spike_o;

  snn_window_classifier dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .in_valid_i(in_valid_i),
    .spike_i(spike_i), .wt_we_i(wt_we_i), .wt_sel_i(wt_sel_i), .wt_addr_i(wt_addr_i),
    .wt_data_i(wt_data_i), .busy_o(busy_o), .done_o(done_o), .class_o(class_o),
    .no_spike_o(no_spike_o), .hid_spike_o(hid_spike_o), .out_spike_o(out_spike_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  int              m_wh [N_HID][N_IN];
  int              m_wo [N_OUT][N_HID];
  logic [N_IN-1:0] stim [T_STEPS];
  logic [N_HID-1:0] exp_hid [T_STEPS];
  logic [N_OUT-1:0] exp_out [T_STEPS];
  int              exp_cls, exp_nos;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic lif(inout int v, inout int thr, input int cur, output bit fire);
    int nv;
    nv = v - (v >> LEAK_SHIFT) + cur;
    if (nv > V_MAX) nv = V_MAX;
    if (nv >= thr) begin
      fire = 1'b1;
      v    = 0;
      thr  = (thr + THRESH_INC > V_MAX) ? V_MAX : thr + THRESH_INC;
    end else begin
      fire = 1'b0;
      v    = nv;
      thr  = (thr - THRESH_DEC < THRESH_MIN) ? THRESH_MIN : thr - THRESH_DEC;
    end
  endtask

  // Step-level reference: the hidden spikes of step s feed the output layer of step s.
  task automatic model_run();
    int hv[N_HID], ht[N_HID], ov[N_OUT], ot[N_OUT], cnt[N_OUT];
    int cur, best;
    bit f;
    for (int j = 0; j < N_HID; j++) begin hv[j] = 0; ht[j] = THRESH_INIT; end
    for (int k = 0; k < N_OUT; k++) begin ov[k] = 0; ot[k] = THRESH_INIT; cnt[k] = 0; end
    for (int s = 0; s < T_STEPS; s++) begin
      for (int j = 0; j < N_HID; j++) begin
        cur = 0;
        for (int i = 0; i < N_IN; i++) if (stim[s][i]) cur += m_wh[j][i];
        lif(hv[j], ht[j], cur, f);
        exp_hid[s][j] = f;
      end
      for (int k = 0; k < N_OUT; k++) begin
        cur = 0;
        for (int j = 0; j < N_HID; j++) if (exp_hid[s][j]) cur += m_wo[k][j];
        lif(ov[k], ot[k], cur, f);
        exp_out[s][k] = f;
        if (f && cnt[k] < CNT_SAT) cnt[k]++;
      end
    end
    best = 0;
    for (int k = 1; k < N_OUT; k++) if (cnt[k] > cnt[best]) best = k;
    exp_cls = best;
    exp_nos = (cnt[best] == 0) ? 1 : 0;
  endtask

  task automatic write_w(input bit sel, input int addr, input int val);
    wt_we_i   = 1'b1;
    wt_sel_i  = sel;
    wt_addr_i = ADDR_W'(addr);
    wt_data_i = W_W'(val);
    @(posedge clk_i); #1;
    wt_we_i   = 1'b0;
  endtask

  task automatic program_all();
    for (int j = 0; j < N_HID; j++)
      for (int i = 0; i < N_IN; i++) write_w(1'b0, j*N_IN + i, m_wh[j][i]);
    for (int k = 0; k < N_OUT; k++)
      for (int j = 0; j < N_HID; j++) write_w(1'b1, k*N_HID + j, m_wo[k][j]);
  endtask

  task automatic set_weights(input int hid_val, input int row_a, input int row_b);
    for (int j = 0; j < N_HID; j++)
      for (int i = 0; i < N_IN; i++) m_wh[j][i] = hid_val;
    for (int k = 0; k < N_OUT; k++)
      for (int j = 0; j < N_HID; j++) m_wo[k][j] = (k == row_a || k == row_b) ? 15 : 0;
  endtask

  // Runs one window from IDLE and checks the debug spikes, latency and result against the model.
  task automatic do_run(input string tag, input int stall_at, input int stall_len,
                        input int stall_pct, input bit wr_busy, output int lat);
    int cyc, step, stalls, pend, left;
    bit iv;
    model_run();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 1;
    check({tag, "/busy_run"}, busy_o, 1);
    step = 0; stalls = 0; pend = -1; left = stall_len;
    while (step < T_STEPS && cyc < 400) begin
      iv = 1'b1;
      if (step == stall_at && left > 0) begin iv = 1'b0; left--; end
      else if (stall_pct > 0 && $urandom_range(99) < stall_pct) iv = 1'b0;
      in_valid_i = iv;
      spike_i    = iv ? stim[step] : N_IN'($urandom);
      if (wr_busy && step >= 10 && step <= 12) begin
        wt_we_i = 1'b1; wt_sel_i = 1'b1;
        wt_addr_i = ADDR_W'(3*N_HID + step - 10); wt_data_i = '0;
      end
      @(posedge clk_i); #1;
      cyc++;
      wt_we_i = 1'b0;
      if (pend >= 0) check({tag, "/out_spike"}, out_spike_o, exp_out[pend]);
      if (iv) begin
        check({tag, "/hid_spike"}, hid_spike_o, exp_hid[step]);
        pend = step;
        step++;
      end else begin
        stalls++;
        pend = -1;
      end
    end
    in_valid_i = 1'b0;
    check({tag, "/steps_taken"}, step, T_STEPS);
    @(posedge clk_i); #1;
    cyc++;
    if (pend >= 0) check({tag, "/out_spike_last"}, out_spike_o, exp_out[pend]);
    while (!done_o && cyc < T_STEPS + stalls + 20) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check({tag, "/latency"}, cyc, T_STEPS + 3 + stalls);
    check({tag, "/done"}, done_o, 1);
    check({tag, "/busy_done"}, busy_o, 0);
    check({tag, "/class"}, class_o, exp_cls);
    check({tag, "/no_spike"}, no_spike_o, exp_nos);
    lat = cyc;
    @(posedge clk_i); #1;
    check({tag, "/done_pulse"}, done_o, 0);
    check({tag, "/class_hold"}, class_o, exp_cls);
  endtask

  initial begin
    int lat, seen_done;
    rst_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; spike_i = '0;
    wt_we_i = 1'b0; wt_sel_i = 1'b0; wt_addr_i = '0; wt_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset and idle behaviour.
    seen_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i); #1;
      if (done_o !== 1'b0) seen_done = 1;
    end
    check("reset/no_done", seen_done, 0);
    check("reset/busy", busy_o, 0);
    check("reset/class", class_o, 0);
    check("reset/no_spike", no_spike_o, 0);
    check("reset/hid_spike", hid_spike_o, 0);
    check("reset/out_spike", out_spike_o, 0);

    // Single winner.
    set_weights(15, 3, 3);
    program_all();
    for (int s = 0; s < T_STEPS; s++) stim[s] = '1;
    do_run("winner", -1, 0, 0, 1'b0, lat);
    check("winner/lat67", lat, 67);
    check("winner/class3", class_o, 3);
    check("winner/nos0", no_spike_o, 0);

    // Stall of five cycles mid-window.
    do_run("stall", 30, 5, 0, 1'b0, lat);
    check("stall/lat72", lat, 72);
    check("stall/class3", class_o, 3);

    // Weight writes while busy are dropped.
    do_run("wr_busy", -1, 0, 0, 1'b1, lat);
    check("wr_busy/class3", class_o, 3);
    do_run("wr_busy_after", -1, 0, 0, 1'b0, lat);

    // Silence.
    for (int s = 0; s < T_STEPS; s++) stim[s] = '0;
    do_run("silence", -1, 0, 0, 1'b0, lat);
    check("silence/lat67", lat, 67);
    check("silence/class0", class_o, 0);
    check("silence/nos1", no_spike_o, 1);

    // Tie goes to the lower index.
    set_weights(15, 2, 7);
    program_all();
    for (int s = 0; s < T_STEPS; s++) stim[s] = '1;
    do_run("tie", -1, 0, 0, 1'b0, lat);
    check("tie/class2", class_o, 2);

    // Reset at step 20 of a window.
    set_weights(15, 3, 3);
    program_all();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    in_valid_i = 1'b1; spike_i = '1;
    repeat (20) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; in_valid_i = 1'b0;
    check("midrst/busy", busy_o, 0);
    check("midrst/class", class_o, 0);
    check("midrst/hid_spike", hid_spike_o, 0);
    seen_done = (done_o !== 1'b0) ? 1 : 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk_i); #1;
      if (done_o !== 1'b0) seen_done = 1;
    end
    check("midrst/no_done", seen_done, 0);
    set_weights(0, -1, -1);
    do_run("midrst_noreload", -1, 0, 0, 1'b0, lat);
    check("midrst_noreload/nos1", no_spike_o, 1);
    set_weights(15, 3, 3);
    program_all();
    do_run("midrst_reload", -1, 0, 0, 1'b0, lat);
    check("midrst_reload/class3", class_o, 3);

    // Randomized weights, inputs and stalls.
    for (int r = 0; r < 6; r++) begin
      int dens;
      dens = $urandom_range(20, 80);
      for (int j = 0; j < N_HID; j++)
        for (int i = 0; i < N_IN; i++) m_wh[j][i] = $urandom_range(15);
      for (int k = 0; k < N_OUT; k++)
        for (int j = 0; j < N_HID; j++) m_wo[k][j] = $urandom_range(15);
      program_all();
      for (int s = 0; s < T_STEPS; s++)
        for (int i = 0; i < N_IN; i++) stim[s][i] = ($urandom_range(99) < dens);
      do_run($sformatf("rand%0d", r), -1, 0, 15, 1'b0, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
